// File: rtl/fmul32_pkg.sv
// Shared types and helpers for the FMUL32 request scheduler.
//   tag_t   : {valid, id} entry carried alongside each in-flight multiply
//   pick_t  : round-robin arbitration result {found, idx}
//   rr_pick : round-robin winner search starting after `last`
package fmul32_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned MAX_REQ    = 8;
    localparam int unsigned MAX_ID_W   = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First valid requester at or after last+1, wrapping modulo n_req.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  valid_vec,
                                      input logic [MAX_ID_W-1:0] last,
                                      input int unsigned         n_req);
        pick_t               p;
        logic [MAX_ID_W-1:0] idx;
        p = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            idx = MAX_ID_W'((32'(last) + k) % n_req);
            if (k <= n_req && !p.found && valid_vec[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fmul32_sched_if.sv
// Requester, core and response signals of the FMUL32 scheduler.
//   master : requester/core side (drives operands and core results)
//   slave  : scheduler side
interface fmul32_sched_if
    import fmul32_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic                    core_in_valid;
    logic [DATA_W-1:0]       core_a;
    logic [DATA_W-1:0]       core_b;
    logic                    core_out_valid;
    logic [DATA_W-1:0]       core_res;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;
    logic                    err;

    modport master (
        output req_valid, req_a, req_b, core_out_valid, core_res,
        input  req_ready, core_in_valid, core_a, core_b,
               rsp_valid, rsp_data, rsp_id, busy, err
    );

    modport slave (
        input  req_valid, req_a, req_b, core_out_valid, core_res,
        output req_ready, core_in_valid, core_a, core_b,
               rsp_valid, rsp_data, rsp_id, busy, err
    );
endinterface

// File: rtl/fmul32_tag_pipe.sv
// Requester-ID pipeline matched to the multiplier latency.
//   clk, rst_n : clock, async active-low reset
//   in_valid   : an operand pair was issued this cycle
//   in_id      : requester that issued it
//   head       : tag aligned with the core's result this cycle
//   any_valid  : some stage holds a live tag
module fmul32_tag_pipe
    import fmul32_pkg::*;
#(
    parameter int unsigned LAT  = 3,
    parameter int unsigned ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [ID_W-1:0] in_id,
    output tag_t            head,
    output logic            any_valid
);

    tag_t stage_q [LAT];
    tag_t stage_d [LAT];

    // Unconditional shift; the core never stalls.
    always_comb begin
        stage_d[0].valid = in_valid;
        stage_d[0].id    = MAX_ID_W'(in_id);
        for (int unsigned i = 1; i < LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            any_valid = any_valid | stage_q[i].valid;
        end
    end

    assign head = stage_q[LAT-1];

endmodule

// File: rtl/fmul32_sched.sv
// Round-robin scheduler sharing one fixed-latency FMUL32 core among N_REQ
// requesters; results are routed back by a tag pipeline.
//   clk, rst_n : clock, async active-low reset
//   bus        : requester valid/ready/operands, core issue/return,
//                one-hot response, busy and sticky err
module fmul32_sched
    import fmul32_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LAT    = 3,
    parameter int unsigned ID_W   = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    fmul32_sched_if.slave bus
);

    logic [MAX_ID_W-1:0] last_q, last_d;
    pick_t               pick_c;
    logic                accept_c;
    logic [N_REQ-1:0]    ready_c;
    logic [DATA_W-1:0]   a_c, b_c;

    tag_t                head;
    logic                pipe_busy;

    logic [N_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                err_q, err_d;

    // Arbitration and issue mux; the winner is always valid, so found == handshake.
    always_comb begin
        pick_c  = rr_pick(MAX_REQ'(bus.req_valid), last_q, N_REQ);
        ready_c = '0;
        a_c     = '0;
        b_c     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_c.found && pick_c.idx == MAX_ID_W'(i)) begin
                ready_c[i] = 1'b1;
                a_c        = bus.req_a[i*DATA_W +: DATA_W];
                b_c        = bus.req_b[i*DATA_W +: DATA_W];
            end
        end
        accept_c = pick_c.found;
        last_d   = accept_c ? pick_c.idx : last_q;
    end

    fmul32_tag_pipe #(
        .LAT  (LAT),
        .ID_W (ID_W)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept_c),
        .in_id     (ID_W'(pick_c.idx)),
        .head      (head),
        .any_valid (pipe_busy)
    );

    // Response steering follows the tag; a core strobe disagreeing with it is flagged.
    always_comb begin
        rsp_valid_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            rsp_valid_d[i] = head.valid && (head.id == MAX_ID_W'(i));
        end
        rsp_id_d   = ID_W'(head.id);
        rsp_data_d = bus.core_res;
        err_d      = err_q | (bus.core_out_valid != head.valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= MAX_ID_W'(N_REQ - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready     = ready_c;
    assign bus.core_in_valid = accept_c;
    assign bus.core_a        = a_c;
    assign bus.core_b        = b_c;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_id        = rsp_id_q;
    assign bus.busy          = pipe_busy | (|rsp_valid_q);
    assign bus.err           = err_q;

endmodule

// File: doc/fmul32_sched.md
# fmul32_sched

Round-robin scheduler that shares one fixed-latency FMUL32 multiplier core between `N_REQ` requesters. It accepts at most one operand pair per cycle and drives the core's input port. It tracks each in-flight operation's requester ID in a tag pipeline matched to the core latency, then routes each core result back to the requester that issued it. It sits between the requester-side valid/ready ports and the combinational/pipelined FMUL32 datapath (normalisation, exponent formation, rounding).

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 32: operand/result width.
- `LAT`, default 3: core latency in cycles from `core_in_valid` to `core_out_valid`, 1..8.
- `ID_W`, default `$clog2(N_REQ)`: requester ID width.

Ports:
- `clk`  in  1  clock; one clock domain, all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester operand valid.
- `req_ready`  out  N_REQ  per-requester accept; one-hot or zero.
- `req_a`  in  N_REQ*DATA_W  operand A of requester i, at slice [i*DATA_W +: DATA_W].
- `req_b`  in  N_REQ*DATA_W  operand B of requester i, same slicing.
- `core_in_valid`  out  1  issue strobe to the core.
- `core_a`, `core_b`  out  DATA_W  operands to the core.
- `core_out_valid`  in  1  core result strobe.
- `core_res`  in  DATA_W  core result.
- `rsp_valid`  out  N_REQ  one-hot result strobe.
- `rsp_data`  out  DATA_W  result, shared by all requesters.
- `rsp_id`  out  ID_W  index of the requester receiving the result.
- `busy`  out  1  any operation in flight.
- `err`  out  1  sticky tag/core mismatch flag.

## Operation
- **Arbitration:** combinational round-robin over `req_valid`, starting at `last+1` and wrapping modulo `N_REQ`.
  - `req_ready[g]=1` only for the winner `g`. `req_ready` depends on `req_valid`.
  - Handshake completes when `req_valid[g] & req_ready[g]`; the operands are accepted that cycle.
  - On acceptance, the `last` register loads `g`. It is unchanged on idle cycles.
- **Issue:** `core_in_valid`, `core_a` and `core_b` are combinational from the winner in the same cycle. When no request is valid, `core_in_valid=0` and the operands are don't-care; they are held at 0 in RTL.
- **Tag pipeline:** a `LAT`-stage shift register of {valid, id}.
  - Stage 0 loads {accept, g} every cycle.
  - Every stage shifts every cycle. The core never stalls, so there is no backpressure inside the pipe.
- **Return:** at the pipe head, the result is registered as follows:
  - `rsp_valid <= head.valid ? onehot(head.id) : 0`
  - `rsp_id <= head.id`
  - `rsp_data <= core_res`
- **Requesters:** each requester must sink its `rsp_valid` unconditionally. There is no response backpressure.
- **Error detection:** if `core_out_valid != head.valid` in any cycle, `err` sets and holds until reset. The response is still generated from `head.valid`.
- **`busy`:** OR of all tag-pipe valid bits and `rsp_valid`.
- **Starvation bound:** a requester holding `req_valid` high is granted within `N_REQ` cycles.

## Timing
- **Reset** (async assert, sync-safe deassert):
  - `last = N_REQ-1`, so requester 0 wins first.
  - All tag-pipe stages are invalid.
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `err=0`, `busy=0`.
  - `req_ready` and `core_in_valid` are 0 while no `req_valid` is high.
- **Latency:** operands accepted in cycle T produce `rsp_valid` in cycle T+LAT+1.
- **Throughput:** one issue per cycle. Back-to-back results are delivered on consecutive cycles, possibly to different requesters.
- **Simultaneous events:** a new accept and a pipe-head return in the same cycle are independent and both proceed.
- **Reset mid-operation:** all in-flight operations are discarded with no response. The requesters re-issue them.
- **Single requester:** with only one requester active, it is granted every cycle; `last` stays at its index.

## Structure
- Shared package `fmul32_pkg` holds:
  - `DATA_W` default;
  - a tag struct typedef {valid, id};
  - the function `rr_pick(valid_vec, last)`, which returns the winner index and a found bit.
- Sub-module `fmul32_tag_pipe` (parameters `LAT`, `ID_W`) holds the shift register and the head outputs.
- The arbiter, issue mux and response register live in the top module.

## Test plan
- **Single request:** reset, then `req_valid=4'b0001` for 1 cycle with a=0x3F800000 (1.0) and b=0x40000000 (2.0), core model LAT=3 -> `rsp_valid=4'b0001`, `rsp_id=0`, `rsp_data=0x40000000` at T+4. `busy` is high from T+1 to T+4.
- **Full contention:** `req_valid=4'b1111` held for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. The eight responses return in the same order, each with the correct product and ID.
- **Wrap-around:** after a grant to 3, `req_valid=4'b1001` -> grant 0, then 3. Starting again from `last=3` with `req_valid=4'b1000` -> grant 3, with no skipped cycle.
- **Mismatch:** the core model drops `core_out_valid` for an issued operation -> `err=1` from the next cycle, held. `rsp_valid` still asserts for that tag.
- **Reset in flight:** issue 3 operations, then assert `rst_n=0` one cycle before the first return -> no `rsp_valid` after reset. `busy=0` and `last=3` while reset is held.
- **Random soak:** random `req_valid` on all ports over 10k cycles -> the scoreboard matches every product and requester ID, and no requester waits more than `N_REQ` cycles while its valid is held.
